// File: rtl/arbitro_pkg.sv
// Shared definitions for the shared 300 ms timebase arbiter.
// Contents:
//   estado_t          - FSM state encoding (REPOSO, CONTANDO, AVISO)
//   CUENTA_300MS_DEF  - default window length in clock cycles (300 ms at 50 MHz)
//   CNT_W_DEF         - default window counter width
//   cabe_en()         - tells whether a counter width can hold a given window length
package arbitro_pkg;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    CONTANDO = 2'd1,
    AVISO    = 2'd2
  } estado_t;

  localparam int CUENTA_300MS_DEF = 15000000;
  localparam int CNT_W_DEF        = 24;

  // True when a cnt_w-bit counter can reach cuenta-1 without wrapping
  function automatic bit cabe_en(input int cnt_w, input int cuenta);
    return (64'(1) << cnt_w) > 64'(cuenta);
  endfunction

endpackage

// File: rtl/contador_ventana.sv
// Window counter for the shared timebase.
// Ports:
//   clk    in  1  clock, rising edge
//   reset  in  1  synchronous, active-high; clears the count
//   clear  in  1  restarts the count at 0 (a new window was granted)
//   enable in  1  advance the count by one this cycle
//   fin    out 1  the count has reached CUENTA-1 (last cycle of the window)
// The count saturates at CUENTA-1 so it can never wrap into a false terminal.
module contador_ventana #(
  parameter int CUENTA = 5,
  parameter int CNT_W  = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic fin
);

  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CUENTA - 1);

  logic [CNT_W-1:0] cuenta;

  // Count up while enabled; hold at the terminal value until the next clear
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cuenta <= '0;
    end else if (enable && !fin) begin
      cuenta <= cuenta + CNT_W'(1);
    end
  end

  assign fin = (cuenta == TERMINAL);

endmodule

// File: rtl/arbitro_temporizador.sv
// Round-robin arbiter that shares one 300 ms timebase among N debouncers.
// Each debouncer holds actCuenta high to ask for a window; the winner gets
// concesion while its window counts, then a single-cycle t300ms pulse.
// Dropping the request before the pulse aborts the window with no pulse.
// Ports:
//   Clk        in  1          system clock, rising edge
//   Reset      in  1          synchronous, active-high
//   actCuenta  in  N_CANALES  per-channel window request (level)
//   t300ms     out N_CANALES  one-hot end-of-window pulse to the granted channel
//   concesion  out N_CANALES  one-hot grant of the running window, 0 when idle
//   ocupado    out 1          high while a window is counting or pulsing
// All outputs are registered.
module arbitro_temporizador
  import arbitro_pkg::*;
#(
  parameter int N_CANALES    = 4,
  parameter int CUENTA_300MS = CUENTA_300MS_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [N_CANALES-1:0] actCuenta,
  output logic [N_CANALES-1:0] t300ms,
  output logic [N_CANALES-1:0] concesion,
  output logic                 ocupado
);

  localparam int IDX_W = (N_CANALES > 1) ? $clog2(N_CANALES) : 1;

  estado_t              estado, estadoSig;
  logic [IDX_W-1:0]     puntero, punteroSig;
  logic [IDX_W-1:0]     ganador, ganadorSig;
  logic [IDX_W-1:0]     candidato;
  logic                 hayCandidato;
  logic [N_CANALES-1:0] concesionSig, t300msSig;
  logic                 limpiarCnt, habilitarCnt, finCnt;
  logic                 cuentaValida;
  int                   idx;

  // Tied off in hardware; kept so a bad CNT_W is easy to spot in a waveform
  assign cuentaValida = cabe_en(CNT_W, CUENTA_300MS);

  contador_ventana #(
    .CUENTA (CUENTA_300MS),
    .CNT_W  (CNT_W)
  ) u_contador (
    .clk    (Clk),
    .reset  (Reset),
    .clear  (limpiarCnt),
    .enable (habilitarCnt),
    .fin    (finCnt)
  );

  // Round-robin picker: first requester scanning upward from puntero+1,
  // wrapping; the last channel served therefore ranks last
  always_comb begin
    candidato    = '0;
    hayCandidato = 1'b0;
    idx          = 0;
    for (int i = 1; i <= N_CANALES; i++) begin
      idx = int'(puntero) + i;
      if (idx >= N_CANALES) begin
        idx = idx - N_CANALES;
      end
      if (!hayCandidato && actCuenta[IDX_W'(idx)]) begin
        hayCandidato = 1'b1;
        candidato    = IDX_W'(idx);
      end
    end
  end

  // Next-state logic. An abort seen on the terminal cycle wins over the
  // pulse; once in AVISO the request is ignored and the pulse is delivered.
  always_comb begin
    estadoSig    = estado;
    concesionSig = concesion;
    t300msSig    = '0;
    punteroSig   = puntero;
    ganadorSig   = ganador;
    limpiarCnt   = 1'b0;
    habilitarCnt = 1'b0;
    unique case (estado)
      REPOSO: begin
        if (hayCandidato) begin
          estadoSig    = CONTANDO;
          ganadorSig   = candidato;
          concesionSig = N_CANALES'(1) << candidato;
          limpiarCnt   = 1'b1;
        end
      end
      CONTANDO: begin
        habilitarCnt = 1'b1;
        if (!actCuenta[ganador]) begin
          estadoSig    = REPOSO;
          concesionSig = '0;
          punteroSig   = ganador;
        end else if (finCnt) begin
          estadoSig = AVISO;
          t300msSig = concesion;
        end
      end
      AVISO: begin
        estadoSig    = REPOSO;
        concesionSig = '0;
        punteroSig   = ganador;
      end
      default: begin
        estadoSig    = REPOSO;
        concesionSig = '0;
      end
    endcase
  end

  // State and output registers; the pointer starts at the last channel so
  // channel 0 is served first after reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      estado    <= REPOSO;
      concesion <= '0;
      t300ms    <= '0;
      ocupado   <= 1'b0;
      puntero   <= IDX_W'(N_CANALES - 1);
      ganador   <= '0;
    end else begin
      estado    <= estadoSig;
      concesion <= concesionSig;
      t300ms    <= t300msSig & {N_CANALES{cuentaValida}};
      ocupado   <= (estadoSig != REPOSO);
      puntero   <= punteroSig;
      ganador   <= ganadorSig;
    end
  end

endmodule
